// File: rtl/mem_access_unit.sv
// Load/store sequencer between the control unit and memory_component.
// Optional build macro MAU_IO_STALL_EN adds io_ready back-pressure for I/O-word accesses.
module mem_access_unit #(
    parameter int              ADDR_W  = 16,
    parameter int              DATA_W  = 16,
    parameter logic [ADDR_W-1:0] IO_ADDR = 16'hFC00,
    parameter int              RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef MAU_IO_STALL_EN
    input  logic              io_ready,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              io_hit,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam int              CNT_W    = $clog2(RD_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit              HAS_WAIT = (RD_LAT > 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              io_sel;
    logic              issue_go;

    assign io_sel = (addr_q == IO_ADDR);

    // An I/O access may be held in ISSUE until the I/O side is ready.
`ifdef MAU_IO_STALL_EN
    assign issue_go = !io_sel || io_ready;
`else
    assign issue_go = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = ISSUE;
            ISSUE: begin
                if (issue_go) begin
                    if (we_q)          state_nxt = DONE;
                    else if (HAS_WAIT) state_nxt = WAIT;
                    else               state_nxt = CAPTURE;
                end
            end
            WAIT:    if (cnt == CNT_ONE) state_nxt = CAPTURE;
            CAPTURE: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                we_q    <= req_we;
            end
            // WAIT exits as the counter steps from 1 to 0.
            if (state == ISSUE && issue_go && !we_q)
                cnt <= CNT_LOAD;
            else if (state == WAIT)
                cnt <= cnt - CNT_ONE;
            if (state == CAPTURE)
                rdata_q <= mem_q;
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign rdata    = rdata_q;
    assign io_hit   = busy && io_sel;
    assign mem_addr = addr_q;
    assign mem_data = wdata_q;
    assign mem_we   = (state == ISSUE) && we_q && issue_go;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequencer between the multi-cycle control unit/datapath and memory_component; it produces the addr/data/we stimulus that memory_component consumes and captures its q.
- Accepts one load/store request at a time, holds address and write data stable for the access, and waits out the memory's registered read latency.
- Returns read data in a memory data register (MDR) with a one-cycle done pulse.
- Flags accesses to the memory-mapped I/O word so the control unit can track I/O traffic.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data width in bits.
- IO_ADDR, 16'hFC00, memory-mapped processor I/O word address.
- RD_LAT, 1, memory read latency in cycles from the address-sampling edge to q valid; legal range 1..3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request strobe from the control unit; sampled only in IDLE.
- req_we  in  1  1 = store, 0 = load; sampled with req.
- req_addr  in  ADDR_W  request address; sampled with req.
- req_wdata  in  DATA_W  store data; sampled with req.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the access completes.
- rdata  out  DATA_W  MDR; holds the last load result.
- io_hit  out  1  high while the latched address equals IDLE-latched IO_ADDR, i.e. while busy and the latched address is IO_ADDR.
- mem_addr  out  ADDR_W  to memory_component addr.
- mem_data  out  DATA_W  to memory_component data.
- mem_we  out  1  to memory_component we.
- mem_q  in  DATA_W  from memory_component q.

Behaviour:
- Reset values: state = IDLE, busy = 0, done = 0, rdata = 0, io_hit = 0, mem_addr = 0, mem_data = 0, mem_we = 0, latency counter = 0.
- Reset asserted mid-access aborts the access immediately at that edge. No done pulse is produced and rdata is cleared.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE:
  - When req = 1, latch req_addr, req_wdata and req_we into internal registers, and go to ISSUE.
  - When req = 0, stay in IDLE.
- ISSUE (exactly one cycle):
  - mem_addr = latched address; mem_data = latched wdata; mem_we = latched we.
  - Store goes to DONE.
  - Load loads the counter with RD_LAT-1. It goes to WAIT if RD_LAT > 1, otherwise to CAPTURE.
- WAIT: mem_we = 0, address held. Counter decrements each cycle; go to CAPTURE on the cycle the counter reaches 0.
- CAPTURE: rdata <= mem_q, then go to DONE.
- DONE: done = 1 for exactly this one cycle; rdata is stable from this cycle onward. Next state is IDLE.
- mem_we is high only during ISSUE of a store, so a store writes exactly once.
- mem_addr and mem_data hold their last value outside an access. mem_addr is never driven X after reset.
- req while busy is ignored and not queued; the control unit must re-assert after done.
- Back-to-back requests: req high in the IDLE cycle that follows DONE is accepted. The minimum period is 3 cycles for a store and 4 + (RD_LAT-1) cycles for a load.
- A store to IO_ADDR is forwarded unchanged; memory_component drives processor_output. A load from IO_ADDR returns processor_input through mem_q like any other address.
- rdata is unchanged by stores.
- Widths: all address and data paths pass through unmodified; no arithmetic except the counter, which is $clog2(RD_LAT)+1 bits wide.

Optional Feature:
- Macro: MAU_IO_STALL_EN.
- Defined:
  - Adds input port io_ready (1 bit).
  - When the latched address equals IO_ADDR, the FSM stays in IDLE-latched holding in ISSUE, with mem_we forced to 0, until io_ready = 1.
  - The write or read is then performed in the cycle io_ready is seen high.
  - Non-I/O accesses are unaffected.
- Undefined: no io_ready port; I/O accesses have the same timing as memory accesses.

Test Plan:
- Reset then idle: hold reset 2 cycles -> busy = 0, done = 0, rdata = 16'h0000, mem_we = 0.
- Load addr 16'h0000 with memory preloaded with 16'hDEAD -> done pulses exactly once, 4 cycles after req; rdata = 16'hDEAD; mem_we never high.
- Store 16'h0420 to 16'h0001, then load 16'h0001 -> mem_we high exactly 1 cycle; done pulse after 3 cycles; then rdata = 16'h0420.
- Store 16'h1AD0 to 16'hFC00 -> io_hit = 1 while busy; memory_component processor_output = 16'h1AD0. Then load 16'hFC00 with processor_input = 16'h0BAD -> rdata = 16'h0BAD.
- req held high through a whole load, with req_addr changed to 16'h0002 in ISSUE -> access uses the latched 16'h0000; the second request starts only after DONE.
- Reset asserted in WAIT (RD_LAT = 3) -> next cycle IDLE, no done pulse, rdata = 0. With MAU_IO_STALL_EN defined, io_ready held low 5 cycles on an FC00 store -> mem_we stays 0 until io_ready rises.
